// File: rtl/regression_sequencer_pkg.sv
// Shared state encoding and default sizing for the regression sequencer slice.
package regression_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        PASS1 = 3'd2,
        PASS2 = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } regseq_state_t;

    localparam int unsigned N_SAMPLES_DEF = 150;
    localparam int unsigned DATA_W_DEF    = 20;
    localparam int unsigned ADDR_W_DEF    = 8;
    localparam int unsigned DRAIN_CYC_DEF = 2;

    // States in which a run is in flight and busy is reported.
    function automatic logic is_busy_state(input regseq_state_t s);
        return (s == CLEAR) || (s == PASS1) || (s == PASS2) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/regression_sequencer_if.sv
// Sample-RAM read port plus coefficient-calculator control/result bundle.
interface regression_sequencer_if
    import regression_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_x;
    logic [DATA_W-1:0] mem_y;
    logic              calc_rst;
    logic              calc_en;
    logic [DATA_W-1:0] calc_x;
    logic [DATA_W-1:0] calc_y;
    logic [DATA_W-1:0] calc_b0;
    logic [DATA_W-1:0] calc_b1;

    modport master (
        output mem_rd_en, mem_addr, calc_rst, calc_en, calc_x, calc_y,
        input  mem_x, mem_y, calc_b0, calc_b1
    );

    modport slave (
        input  mem_rd_en, mem_addr, calc_rst, calc_en, calc_x, calc_y,
        output mem_x, mem_y, calc_b0, calc_b1
    );
endinterface

// File: rtl/regression_sequencer_addr_counter.sv
// Sample address counter: wraps to zero after N_SAMPLES-1, flags terminal count.
module regseq_addr_counter
    import regression_pkg::*;
#(
    parameter int unsigned N_SAMPLES = N_SAMPLES_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    output logic [ADDR_W-1:0] count,
    output logic              tc
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_SAMPLES - 1);

    assign tc = (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/regression_sequencer.sv
// Sequences the two-pass regression calculator over the stored sample set.
// Optional abort support is compiled in when REGSEQ_ABORT_EN is defined.
module regression_sequencer
    import regression_pkg::*;
#(
    parameter int unsigned N_SAMPLES = N_SAMPLES_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_W-1:0]      coef_b0,
    output logic [DATA_W-1:0]      coef_b1,
`ifdef REGSEQ_ABORT_EN
    input  logic                   abort,
    output logic                   aborted,
`endif
    regression_sequencer_if.master bus
);
    localparam int unsigned        DRAIN_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);

    regseq_state_t     state;
    logic [ADDR_W-1:0] count;
    logic              tc;
    logic              cnt_en;
    logic              cnt_clr;
    logic              abort_hit;
    logic              rd_en_q;
    logic              en_q;
    logic              clr_q;
    logic [DRAIN_W-1:0] drain_cnt;

`ifdef REGSEQ_ABORT_EN
    assign abort_hit = abort && is_busy_state(state);
`else
    assign abort_hit = 1'b0;
`endif

    assign cnt_en  = (state == PASS1) || (state == PASS2);
    assign cnt_clr = (state == CLEAR) || abort_hit;

    regseq_addr_counter #(
        .N_SAMPLES (N_SAMPLES),
        .ADDR_W    (ADDR_W)
    ) u_addr_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .count (count),
        .tc    (tc)
    );

    // Calculator is held in clear for the whole reset, not just until the first edge.
    assign bus.calc_rst  = clr_q | ~rst_n;
    assign bus.mem_rd_en = rd_en_q;
    assign bus.mem_addr  = count;
    assign bus.calc_en   = en_q;
    assign bus.calc_x    = bus.mem_x;
    assign bus.calc_y    = bus.mem_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en_q   <= 1'b0;
            en_q      <= 1'b0;
            clr_q     <= 1'b0;
            drain_cnt <= '0;
            coef_b0   <= '0;
            coef_b1   <= '0;
`ifdef REGSEQ_ABORT_EN
            aborted   <= 1'b0;
`endif
        end else begin
            done  <= 1'b0;
            clr_q <= 1'b0;
            // Enable trails the read strobe by the RAM's one-cycle read latency.
            en_q  <= rd_en_q;
`ifdef REGSEQ_ABORT_EN
            aborted <= 1'b0;
`endif
            if (abort_hit) begin
                state   <= IDLE;
                busy    <= 1'b0;
                rd_en_q <= 1'b0;
                en_q    <= 1'b0;
`ifdef REGSEQ_ABORT_EN
                aborted <= 1'b1;
`endif
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state <= CLEAR;
                            busy  <= 1'b1;
                            clr_q <= 1'b1;
                        end
                    end
                    CLEAR: begin
                        state   <= PASS1;
                        rd_en_q <= 1'b1;
                    end
                    PASS1: begin
                        if (tc) begin
                            state <= PASS2;
                        end
                    end
                    PASS2: begin
                        if (tc) begin
                            state     <= DRAIN;
                            rd_en_q   <= 1'b0;
                            drain_cnt <= '0;
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt == DRAIN_LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        coef_b0 <= bus.calc_b0;
                        coef_b1 <= bus.calc_b1;
                        state   <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/regression_sequencer.md
# regression_sequencer

Sequences the two-pass linear-regression coefficient calculator over a stored sample set. On `start` it clears the calculator, streams the N (x, y) samples from the sample RAM twice, and waits for the calculator to settle. It then latches `b_0`/`b_1` into held output registers and pulses `done`. It sits between the sample RAM and the coefficient calculator and is the only agent driving the calculator's `rst`/`En`.

## Interface
- `N_SAMPLES`, 150: samples per pass; must be ≥ 2.
- `ADDR_W`, 8: sample RAM address width; 2^ADDR_W ≥ N_SAMPLES.
- `DATA_W`, 20: sample and coefficient width.
- `DRAIN_CYC`, 2: settle cycles after the last calculator enable.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request, sampled only in IDLE.
- `busy`  out  1  high from CLEAR through DRAIN.
- `done`  out  1  one-cycle pulse; coefficients valid.
- `mem_rd_en`  out  1  RAM read strobe.
- `mem_addr`  out  ADDR_W  RAM read address.
- `mem_x`, `mem_y`  in  DATA_W  RAM read data, valid the cycle after `mem_rd_en`.
- `calc_rst`  out  1  calculator synchronous clear.
- `calc_en`  out  1  calculator enable.
- `calc_x`, `calc_y`  out  DATA_W  calculator operands; combinational pass-through of `mem_x`/`mem_y`.
- `calc_b0`, `calc_b1`  in  DATA_W  calculator results.
- `coef_b0`, `coef_b1`  out  DATA_W  latched results, held until the next `done`.
- `abort`  in  1  present only with `REGSEQ_ABORT_EN`.
- `aborted`  out  1  present only with `REGSEQ_ABORT_EN`.

## Operation
- States: IDLE, CLEAR, PASS1, PASS2, DRAIN, DONE.
- IDLE: wait for `start`; `start` = 1 → CLEAR.
- CLEAR: `calc_rst` = 1 for exactly one cycle; address counter is cleared to 0 → PASS1.
- PASS1 and PASS2 each run for N_SAMPLES cycles:
  - `mem_rd_en` = 1 and `mem_addr` = counter on every cycle of the pass.
  - The counter increments each cycle.
  - At counter = N_SAMPLES−1 the counter wraps to 0 and the FSM advances (PASS1 → PASS2, PASS2 → DRAIN).
- `calc_en` is `mem_rd_en` delayed one cycle (registered), so enables are contiguous across the PASS1/PASS2 boundary: exactly 2·N_SAMPLES enable cycles, none extra.
- DRAIN: DRAIN_CYC cycles with `calc_en` = 0 → DONE.
- DONE (one cycle):
  - `coef_b0` ← `calc_b0` and `coef_b1` ← `calc_b1`.
  - `done` = 1 (registered output).
  - → IDLE.
- `start` outside IDLE is ignored; there is no queuing.
- `start` asserted in the cycle DONE returns to IDLE is accepted on the following edge as usual.
- Reset state:
  - FSM = IDLE, counter = 0.
  - `busy`, `done`, `mem_rd_en`, `calc_en`, `aborted` = 0.
  - `calc_rst` = 1 while `rst_n` is low, 0 after release.
  - `mem_addr`, `coef_b0`, `coef_b1` = 0.
- Reset mid-run: all of the above apply immediately (asynchronous); no partial coefficients are latched.

## Timing
- `start` high at edge 0 gives:
  - CLEAR during cycle 1.
  - Reads during cycles 2 .. 2N+1.
  - `calc_en` high during cycles 3 .. 2N+2.
  - DRAIN during cycles 2N+2 .. 2N+1+DRAIN_CYC.
  - `done` during cycle 2N+2+DRAIN_CYC.
- Start-to-`done` latency is 2·N_SAMPLES+2+DRAIN_CYC cycles; for the defaults this is 304.
- `busy` rises the cycle after `start` and falls in the DONE cycle.
- `coef_*` change only on the edge ending DONE.

## Configuration
- Macro `REGSEQ_ABORT_EN`.
- Defined:
  - `abort` = 1 in any busy state forces IDLE on the next edge.
  - `mem_rd_en`/`calc_en` deassert on that edge.
  - `coef_*` are unchanged.
  - `done` is not pulsed.
  - `aborted` pulses for one cycle.
  - `abort` in IDLE or DONE is ignored.
  - `abort` and `start` together in IDLE: `start` wins.
- Undefined: the `abort`/`aborted` ports and their logic are absent; every run completes.

## Structure
- Shared package `regression_pkg`:
  - state enum `regseq_state_t`.
  - `N_SAMPLES_DEF` = 150.
  - `DATA_W_DEF` = 20.
  - `ADDR_W_DEF` = 8.
- One sub-module, `regseq_addr_counter`: wrap-at-N counter with enable, synchronous clear and terminal-count output.

## Test plan
- Reset and `start` with N=150, sample RAM x=i, y=2i+3: `done` at cycle 304; exactly 300 `calc_en` cycles; `coef_b1` = 2 and `coef_b0` = 3 (per the calculator model).
- `start` held high continuously: runs are back-to-back; each `done` is spaced 305 cycles apart; none are skipped or merged.
- N_SAMPLES=4:
  - `mem_addr` sequence is 0,1,2,3,0,1,2,3.
  - `calc_en` is high during cycles 3–10 with no gap.
  - `calc_rst` is high in cycle 1 only.
- `rst_n` low at cycle 100:
  - All outputs return to reset values asynchronously.
  - `coef_*` keep 0.
  - A following `start` gives full 304-cycle latency.
- Pulse `start` while `busy`: ignored; `done` count = 1.
- With `REGSEQ_ABORT_EN`, `abort` at cycle 50:
  - `aborted` is high in cycle 51.
  - `busy` = 0 and `calc_en` = 0 from cycle 51.
  - No `done`; `coef_*` unchanged.
